// File: rtl/transmitter_pkg.sv
// Shared state encoding and width helper for the UART transmit/receive controllers.
package transmitter_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle.
module baud_tick_counter
    import transmitter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned             CNT_W = clog2_min1(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]        LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tc      = w_at_last & i_en;

    // Restart from zero after the terminal cycle so each bit period is identical.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/transmitter_controller.sv
// UART transmit sequencer: START, DATA, optional PARITY and STOP bit timing.
// Optional parity bit is enabled by defining TX_CTRL_PARITY_EN.
module transmitter_controller
    import transmitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic                  o_state_is_START,
    output logic                  o_state_is_DATA,
    output logic                  o_state_is_PARITY,
    output logic                  o_parity,
    output logic                  o_equal,
    output logic                  o_done
);

    localparam int unsigned      BIT_W    = clog2_min1(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next_state;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_value;
    logic                w_idle;
    logic                w_accept;
    logic                w_tc;
    logic                w_last_bit;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = i_valid & w_idle;
    assign w_last_bit = (r_bit_cnt == LAST_BIT);

    baud_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_idle),
        .i_en    (~w_idle),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every transition out of a bit state happens on the baud terminal count.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_START;
            ST_START:  if (w_tc) w_next_state = ST_DATA;
            ST_DATA: begin
                if (w_tc && w_last_bit) begin
`ifdef TX_CTRL_PARITY_EN
                    w_next_state = ST_PARITY;
`else
                    w_next_state = ST_STOP;
`endif
                end
            end
`ifdef TX_CTRL_PARITY_EN
            ST_PARITY: if (w_tc) w_next_state = ST_STOP;
`endif
            ST_STOP:   if (w_tc) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_value <= '0;
        end else if (w_accept) begin
            r_value <= i_data;
        end
    end

    // Bit index only advances inside DATA; held at zero everywhere else.
    always_ff @(posedge i_clock) begin
        if (i_reset || (r_state != ST_DATA)) begin
            r_bit_cnt <= '0;
        end else if (w_tc) begin
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
        end
    end

`ifdef TX_CTRL_PARITY_EN
    logic r_parity;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^i_data;
        end
    end

    assign o_parity          = r_parity;
    assign o_state_is_PARITY = (r_state == ST_PARITY);
`else
    assign o_parity          = 1'b0;
    assign o_state_is_PARITY = 1'b0;
`endif

    assign o_ready          = w_idle;
    assign o_value          = r_value;
    assign o_state_is_START = (r_state == ST_START);
    assign o_state_is_DATA  = (r_state == ST_DATA);
    assign o_equal          = (r_state == ST_DATA) & w_tc;
    assign o_done           = (r_state == ST_STOP) & w_tc;

endmodule
